ama_riscv_mem_arbiter: RTL and testbench

AMA_RISCV_MEM_ARBITER -- requirements
Module: ama_riscv_mem_arbiter

---
 rtl/ama_riscv_mem_arbiter.sv | 73 +++++++
 tb/tb_ama_riscv_mem_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ama_riscv_mem_arbiter.sv
// ama_riscv_mem_arbiter: fetch/data arbiter onto one single-port sync memory, 1-cycle read response.
// Define AMA_RISCV_ARB_RR_EN for round-robin instead of data-priority with fetch starvation override.
module ama_riscv_mem_arbiter #(
  parameter int AW = 14,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_flush,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic [3:0]    d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          m_en,
  output logic [3:0]    m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_din,
  input  logic [31:0]   m_dout,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          fetch_starved
);
  logic d_win;
  logic tag_v_q, tag_v_d, tag_i_q, tag_i_d;
`ifdef AMA_RISCV_ARB_RR_EN
  // ptr_q=1 gives fetch the win on the next conflict
  logic ptr_q, ptr_d;
  assign fetch_starved = 1'b0;
  always_comb begin
    d_win = d_req & ~(i_req & ptr_q);
    ptr_d = rst ? 1'b0 : (i_req & d_req) ? d_win : ptr_q;
  end
  always_ff @(posedge clk) ptr_q <= ptr_d;
`else
  localparam int CW = $clog2(STARVE_LIM + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign fetch_starved = ~rst & (cnt_q == CW'(STARVE_LIM));
  always_comb begin
    d_win = d_req & ~(i_req & fetch_starved);
    cnt_d = (rst | ~i_req | i_gnt) ? '0 : fetch_starved ? cnt_q : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) cnt_q <= cnt_d;
`endif
  always_comb begin
    d_gnt = ~rst & d_win;
    i_gnt = ~rst & i_req & ~d_win;
    m_en = i_gnt | d_gnt;
    m_we = d_gnt ? d_we : 4'h0;
    m_addr = d_gnt ? d_addr : i_addr;
    m_din = d_wdata;
    stall_if = ~rst & i_req & ~i_gnt;
    stall_mem = ~rst & d_req & ~d_gnt;
    // a fetch granted under flush is dropped before it ever becomes pending
    tag_v_d = ~rst & ((d_gnt & ~|d_we) | (i_gnt & ~i_flush));
    tag_i_d = i_gnt;
    i_rvalid = ~rst & tag_v_q & tag_i_q & ~i_flush;
    d_rvalid = ~rst & tag_v_q & ~tag_i_q;
    i_rdata = m_dout;
    d_rdata = m_dout;
  end
  always_ff @(posedge clk) begin
    tag_v_q <= tag_v_d;
    tag_i_q <= tag_i_d;
  end
endmodule

// File: tb/tb_ama_riscv_mem_arbiter.sv
// tb_ama_riscv_mem_arbiter: directed bench with response scoreboard and behavioural memory.
module tb_ama_riscv_mem_arbiter;
  localparam int AW = 14;
  localparam int LIM = 4;
  logic clk, rst;
  logic i_req, i_flush, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr, d_addr, m_addr;
  logic [31:0] i_rdata, d_rdata, d_wdata, m_din, m_dout;
  logic d_req, d_gnt, d_rvalid, m_en;
  logic [3:0] d_we, m_we;
  logic stall_if, stall_mem, fetch_starved;
  int checks = 0;
  int errors = 0;
  typedef struct { logic src; logic [31:0] data; } rsp_t;
  rsp_t q[$];
  logic [31:0] mem [0:(1<<AW)-1];

  ama_riscv_mem_arbiter #(.AW(AW), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout),
    .stall_if(stall_if), .stall_mem(stall_mem), .fetch_starved(fetch_starved)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [AW-1:0] a);
    return (a == 14'h10) ? 32'h00000013 : (a == 14'h8) ? 32'h11223344 : (32'hA5000000 | 32'(a));
  endfunction

  initial begin
    m_dout = 32'h0;
    for (int a = 0; a < (1 << AW); a++) mem[a] = init_val(AW'(a));
  end

  always @(posedge clk)
    if (m_en) begin
      m_dout <= mem[m_addr];
      for (int b = 0; b < 4; b++)
        if (m_we[b]) mem[m_addr][8*b +: 8] <= m_din[8*b +: 8];
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && (i_rvalid || d_rvalid)) begin
      rsp_t r;
      chk("one_rvalid", {31'b0, i_rvalid & d_rvalid}, 32'h0);
      chk("sb_nonempty", {31'b0, q.size() != 0}, 32'h1);
      if (q.size() != 0) begin
        r = q.pop_front();
        chk("sb_src", {31'b0, i_rvalid}, {31'b0, r.src});
        chk("sb_data", i_rvalid ? i_rdata : d_rdata, r.data);
      end
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    i_req = 0; d_req = 0; i_flush = 0; d_we = 4'h0;
  endtask

  task automatic do_reset;
    tick; idle; rst = 1;
    tick; rst = 0;
  endtask

  task automatic push(input logic src, input logic [31:0] data);
    rsp_t r;
    r.src = src;
    r.data = data;
    q.push_back(r);
  endtask

  initial begin
    clk = 0; rst = 1; idle; i_addr = '0; d_addr = '0; d_wdata = '0;
    tick; i_req = 1; d_req = 1; d_we = 4'hF; #2;
    chk("rst_gnt", {30'b0, i_gnt, d_gnt}, 32'h0);
    chk("rst_mem", {27'b0, m_en, m_we}, 32'h0);
    chk("rst_misc", {27'b0, stall_if, stall_mem, fetch_starved, i_rvalid, d_rvalid}, 32'h0);
    tick; rst = 0; idle;
    // fetch-only read
    tick; i_req = 1; i_addr = 14'h10; #2;
    chk("f_gnt", {30'b0, i_gnt, d_gnt}, 32'h2);
    chk("f_mem", {27'b0, m_en, m_we}, 32'h10);
    chk("f_addr", 32'(m_addr), 32'h10);
    push(1, 32'h00000013);
    tick; idle; #2;
    chk("f_rvalid", {31'b0, i_rvalid}, 32'h1);
    chk("f_rdata", i_rdata, 32'h00000013);
    chk("f_idle_en", {31'b0, m_en}, 32'h0);
    // simultaneous data read and fetch
    do_reset;
    tick; i_req = 1; i_addr = 14'h4; d_req = 1; d_addr = 14'h20; #2;
    chk("c0_gnt", {30'b0, i_gnt, d_gnt}, 32'h1);
    chk("c0_stall", {30'b0, stall_if, stall_mem}, 32'h2);
    chk("c0_addr", 32'(m_addr), 32'h20);
    push(0, init_val(14'h20));
    tick; d_req = 0; #2;
    chk("c1_gnt", {30'b0, i_gnt, d_gnt}, 32'h2);
    chk("c1_stall", {31'b0, stall_if}, 32'h0);
    chk("c1_drv", {31'b0, d_rvalid}, 32'h1);
    push(1, init_val(14'h4));
    tick; idle; #2;
    chk("c2_irv", {30'b0, i_rvalid, stall_if}, 32'h2);
    // continuous conflict: starvation override or round-robin alternation
    do_reset;
    for (int c = 0; c < 6; c++) begin
      logic exp_i, exp_s;
`ifdef AMA_RISCV_ARB_RR_EN
      exp_i = (c % 2) == 1;
      exp_s = 0;
`else
      exp_i = (c == LIM);
      exp_s = (c == LIM);
`endif
      tick; i_req = 1; i_addr = 14'h4; d_req = 1; d_addr = 14'h20; #2;
      chk("sv_gnt", {30'b0, i_gnt, d_gnt}, {30'b0, exp_i, ~exp_i});
      chk("sv_starved", {31'b0, fetch_starved}, {31'b0, exp_s});
      push(exp_i, exp_i ? init_val(14'h4) : init_val(14'h20));
    end
    tick; idle;
    // flush while fetch response is due; data read in same cycle survives
    tick; i_req = 1; i_addr = 14'h10; #2;
    chk("fl_gnt", {31'b0, i_gnt}, 32'h1);
    tick; idle; i_flush = 1; d_req = 1; d_addr = 14'h8; #2;
    chk("fl_irv", {31'b0, i_rvalid}, 32'h0);
    chk("fl_dgnt", {31'b0, d_gnt}, 32'h1);
    push(0, init_val(14'h8));
    tick; idle; #2;
    chk("fl_drv", {31'b0, d_rvalid}, 32'h1);
    // flush in the grant cycle cancels that fetch
    tick; i_req = 1; i_addr = 14'h10; i_flush = 1; #2;
    chk("flg_gnt", {31'b0, i_gnt}, 32'h1);
    tick; idle; #2;
    chk("flg_irv", {31'b0, i_rvalid}, 32'h0);
    // partial write beats fetch, then fetch, then read-back
    do_reset;
    tick; d_req = 1; d_we = 4'b0011; d_addr = 14'h8; d_wdata = 32'hAABBCCDD; i_req = 1; i_addr = 14'h10; #2;
    chk("w_gnt", {30'b0, i_gnt, d_gnt}, 32'h1);
    chk("w_we", {28'b0, m_we}, 32'h3);
    chk("w_din", m_din, 32'hAABBCCDD);
    chk("w_stall", {31'b0, stall_if}, 32'h1);
    tick; d_req = 0; d_we = 4'h0; #2;
    chk("w_fgnt", {31'b0, i_gnt}, 32'h1);
    chk("w_nodrv", {31'b0, d_rvalid}, 32'h0);
    push(1, 32'h00000013);
    tick; idle; d_req = 1; d_addr = 14'h8; #2;
    chk("rb_gnt", {28'b0, d_gnt, m_we}, 32'h10);
    chk("rb_irv", {31'b0, i_rvalid}, 32'h1);
    push(0, 32'h1122CCDD);
    tick; idle; #2;
    chk("rb_drv", {31'b0, d_rvalid}, 32'h1);
    chk("rb_data", d_rdata, 32'h1122CCDD);
    chk("rb_idle", {30'b0, m_en, i_gnt}, 32'h0);
    // reset drops a pending read
    tick; d_req = 1; d_addr = 14'h8; #2;
    chk("rd_gnt", {31'b0, d_gnt}, 32'h1);
    tick; idle; rst = 1; #2;
    chk("rd_rst_rv", {30'b0, i_rvalid, d_rvalid}, 32'h0);
    tick; rst = 0; #2;
    chk("rd_post_rv", {30'b0, i_rvalid, d_rvalid}, 32'h0);
    tick; tick;
    chk("sb_empty", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
